mul64_rr_sched: RTL
===================

Name: mul64_rr_sched

Overview:
- Round-robin scheduler that time-shares one 64x64 unsigned multiplier (128-bit product) among NREQ requesters.
- Each requester issues an operand pair over a valid/ready channel. The block accepts one request at a time and drives registered operands to the multiplier.
- It waits a fixed settle/pipeline latency, captures the product, and returns it on a single shared response channel tagged with the requester index.
- Sits between client engines and the shared multiplier instance.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 64, operand width; product width is 2*WIDTH
- LAT, 2, cycles from operand registers valid to product sampled (>=1; covers combinational settle or multiplier pipeline depth)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; at most one bit high
- req_a  in  NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  operand B, same packing
- mul_a  out  WIDTH  registered operand A to multiplier
- mul_b  out  WIDTH  registered operand B to multiplier
- mul_p  in  2*WIDTH  product from multiplier
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_prod  out  2*WIDTH  registered product
- rsp_id  out  clog2(NREQ)  index of requester that owns rsp_prod
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE; mul_a, mul_b, rsp_prod, rsp_id = 0; rsp_valid=0.
  - Round-robin pointer last=NREQ-1, so requester 0 wins first.
  - rst overrides everything mid-operation: any in-flight op is dropped and no response is produced.
- States: IDLE, WAIT, RESP.
- IDLE:
  - Winner g = first i with req_valid[i]=1, searching last+1, last+2, ... modulo NREQ.
  - req_ready[g]=1, combinational from req_valid and last; all other bits 0. No valid -> req_ready=0.
  - On transfer (req_valid[g] & req_ready[g]): mul_a<=req_a[g], mul_b<=req_b[g], rsp_id<=g, last<=g, cnt<=LAT-1, go WAIT.
- WAIT:
  - req_ready=0. cnt decrements each cycle.
  - When cnt==0: rsp_prod<=mul_p, rsp_valid<=1, go RESP.
  - Result: mul_p is sampled exactly LAT cycles after mul_a/mul_b update.
- RESP:
  - req_ready=0. rsp_valid, rsp_prod, rsp_id held stable until rsp_ready=1.
  - On rsp_valid & rsp_ready: rsp_valid<=0, go IDLE. rsp_prod and rsp_id retain their value.
- Latency: accept edge to rsp_valid high = LAT+1 cycles. Minimum issue interval = LAT+2 cycles with rsp_ready tied high.
- mul_a and mul_b only change on an accept and are stable through WAIT and RESP.
- Arithmetic: product is purely unsigned, 2*WIDTH bits, no truncation. The block passes mul_p through unmodified.
- Requester rules:
  - Must hold req_valid and operands until accepted. Deasserting before accept is permitted and drops the request.
  - Requests arriving during WAIT or RESP wait; they are never lost or reordered within a requester.
- Fairness: with all requesters continuously valid, the grant order is 0,1,...,NREQ-1,0,...
- A requester that is not valid is skipped without consuming a slot.
- Simultaneous rsp handshake and new req_valid: the new request is not accepted in that cycle. It is accepted the next cycle in IDLE.

Test Plan:
- Reset then single request: req_valid=0001, a=3, b=5, LAT=2, rsp_ready=1 -> req_ready[0] high at cycle 0; rsp_valid at cycle 3 with rsp_prod=15, rsp_id=0; busy low at cycle 4.
- Max operands: a=b=64'hFFFF_FFFF_FFFF_FFFF on requester 2 -> rsp_prod=128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, rsp_id=2.
- All four requesters valid continuously with a=i+1, b=10 -> rsp_id sequence 0,1,2,3,0; products 10,20,30,40,10; responses spaced 4 cycles apart.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_prod/rsp_id stable, req_ready stays 0000 while requester 1 is valid; requester 1 is accepted the cycle after rsp_ready rises.
- Skip idle requesters: only requesters 1 and 3 valid, last=3 after reset sequence -> grants alternate 1,3,1; requesters 0 and 2 never see req_ready.
- Reset in WAIT: assert rst one cycle after accept -> no rsp_valid ever rises for that op; next request from requester 0 wins first with correct product.

Source files
------------

// File: rtl/mul64_rr_sched.sv
// Round-robin scheduler sharing one 64x64 unsigned multiplier among NREQ
// requesters. One op in flight: accept, wait LAT cycles, return the product
// tagged with the requester index on a shared response channel.
module mul64_rr_sched #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 64,
   parameter int LAT   = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req_valid,
   output logic [NREQ-1:0]           req_ready,
   input  logic [NREQ*WIDTH-1:0]     req_a,
   input  logic [NREQ*WIDTH-1:0]     req_b,
   output logic [WIDTH-1:0]          mul_a,
   output logic [WIDTH-1:0]          mul_b,
   input  logic [2*WIDTH-1:0]        mul_p,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [2*WIDTH-1:0]        rsp_prod,
   output logic [$clog2(NREQ)-1:0]   rsp_id,
   output logic                      busy
);

   localparam int IDW = $clog2(NREQ);
   localparam int CW  = (LAT > 1) ? $clog2(LAT) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t             state_q, state_d;
   logic [IDW-1:0]     last_q, last_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
   logic [2*WIDTH-1:0] rsp_prod_q, rsp_prod_d;
   logic [IDW-1:0]     rsp_id_q, rsp_id_d;
   logic               rsp_valid_q, rsp_valid_d;

   logic               grant_vld;
   logic [IDW-1:0]     grant_idx;
   logic [IDW-1:0]     cand;
   int                 rr_idx;
   logic               accept;

   logic [WIDTH-1:0]   a_arr [NREQ];
   logic [WIDTH-1:0]   b_arr [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
      assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
   end

   // Round-robin search starting after last grant; the nearest valid
   // requester is visited last so it overwrites farther candidates.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      rr_idx    = 0;
      cand      = '0;
      for (int k = NREQ; k >= 1; k--) begin
         rr_idx = int'(last_q) + k;
         if (rr_idx >= NREQ) rr_idx = rr_idx - NREQ;
         cand = IDW'(rr_idx);
         if (req_valid[cand]) begin
            grant_vld = 1'b1;
            grant_idx = cand;
         end
      end
   end

   // Grant only happens in IDLE; a winner always has its valid high.
   assign accept = (state_q == S_IDLE) && grant_vld;

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_WAIT;
         S_WAIT:  if (cnt_q == '0) state_d = S_RESP;
         S_RESP:  if (rsp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode: one-hot ready to the winner while idle.
   always_comb begin
      req_ready = '0;
      if (accept) req_ready[grant_idx] = 1'b1;
      busy = (state_q != S_IDLE);
   end

   // Datapath next values: operand capture, countdown, product capture.
   always_comb begin
      last_d      = last_q;
      cnt_d       = cnt_q;
      mul_a_d     = mul_a_q;
      mul_b_d     = mul_b_q;
      rsp_prod_d  = rsp_prod_q;
      rsp_id_d    = rsp_id_q;
      rsp_valid_d = rsp_valid_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               mul_a_d  = a_arr[grant_idx];
               mul_b_d  = b_arr[grant_idx];
               rsp_id_d = grant_idx;
               last_d   = grant_idx;
               cnt_d    = CW'(LAT - 1);
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) begin
               rsp_prod_d  = mul_p;
               rsp_valid_d = 1'b1;
            end
         end
         S_RESP: begin
            if (rsp_ready) rsp_valid_d = 1'b0;
         end
         default: ;
      endcase
   end

   // State and datapath registers; reset drops any in-flight op.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         last_q      <= IDW'(NREQ - 1);
         cnt_q       <= '0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         rsp_prod_q  <= '0;
         rsp_id_q    <= '0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         cnt_q       <= cnt_d;
         mul_a_q     <= mul_a_d;
         mul_b_q     <= mul_b_d;
         rsp_prod_q  <= rsp_prod_d;
         rsp_id_q    <= rsp_id_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;
   assign rsp_prod  = rsp_prod_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_valid = rsp_valid_q;

endmodule
